lmac_fifo_rd_framer: RTL

- Downstream consumer of the LMAC packet data FIFO.
- Pops FIFO words through the FIFO's read-request / 1-cycle-latency read port and checks SOP/EOP framing carried in the top two data bits.
- Forwards words as a valid/ready stream with per-packet length, through a 2-entry skid buffer that sustains one word per cycle under backpressure.

---
 rtl/lmac_fifo_rd_framer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lmac_fifo_rd_framer.sv
// Pops the LMAC packet FIFO, checks SOP/EOP framing and forwards words as a valid/ready stream
// through a 2-entry skid buffer. Define LMAC_FRAMER_STATS_EN to add packet/drop/error counters.
module lmac_fifo_rd_framer #(
  parameter int DW   = 64,
  parameter int LENW = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            fifo_rden,
  input  logic [DW+1:0]   fifo_dataout,
  input  logic            fifo_rdempty,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic            m_sop,
  output logic            m_eop,
  output logic [LENW-1:0] m_len,
  output logic            frm_err
`ifdef LMAC_FRAMER_STATS_EN
  ,
  output logic [31:0]     pkt_cnt,
  output logic [31:0]     drop_cnt,
  output logic [15:0]     err_cnt
`endif
);

  localparam logic [LENW-1:0] LEN_MAX = {LENW{1'b1}};

  typedef enum logic {IDLE, PKT} state_t;

  typedef struct packed {
    logic            sop;
    logic            eop;
    logic [LENW-1:0] len;
    logic [DW-1:0]   data;
  } entry_t;

  state_t          state, state_nxt;
  logic [LENW-1:0] len_q, len_nxt;
  entry_t          head_q, tail_q, cap_entry;
  logic [1:0]      buf_cnt;
  logic            inflight;
  logic            fwd, err, pop;
  logic            w_sop, w_eop;
  logic [2:0]      occ;

  assign pop = m_valid & m_ready;
  assign occ = {1'b0, buf_cnt} + {2'b00, inflight};
  // Only request a word when a buffer slot is guaranteed for it one cycle later.
  assign fifo_rden = enable & ~fifo_rdempty & ~reset & ((occ - {2'b00, pop}) < 3'd2);

  assign w_sop = fifo_dataout[DW];
  assign w_eop = fifo_dataout[DW+1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      len_q <= len_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    fwd       = 1'b0;
    err       = 1'b0;
    if (inflight) begin
      if (w_sop) begin
        // A SOP inside a packet means the previous EOP was lost; restart anyway.
        fwd       = 1'b1;
        err       = (state == PKT);
        len_nxt   = LENW'(1);
        state_nxt = w_eop ? IDLE : PKT;
      end else if (state == PKT) begin
        fwd       = 1'b1;
        len_nxt   = (len_q == LEN_MAX) ? len_q : len_q + LENW'(1);
        state_nxt = w_eop ? IDLE : PKT;
      end else begin
        err = 1'b1;
      end
    end
    cap_entry = '{sop: w_sop, eop: w_eop, len: len_nxt, data: fifo_dataout[DW-1:0]};
  end

  // Head keeps its last contents when the buffer drains so m_* stay quiet between packets.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      buf_cnt  <= 2'd0;
      inflight <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      inflight <= fifo_rden;
      frm_err  <= err;
      case ({fwd, pop})
        2'b01: begin
          if (buf_cnt == 2'd2) head_q <= tail_q;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b10: begin
          if (buf_cnt == 2'd0) head_q <= cap_entry;
          else                 tail_q <= cap_entry;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            head_q <= cap_entry;
          end else begin
            head_q <= tail_q;
            tail_q <= cap_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = head_q.data;
  assign m_sop   = head_q.sop;
  assign m_eop   = head_q.eop;
  assign m_len   = head_q.len;

`ifdef LMAC_FRAMER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (pop & m_eop)     pkt_cnt  <= pkt_cnt + 32'd1;
      if (inflight & ~fwd) drop_cnt <= drop_cnt + 32'd1;
      if (err)             err_cnt  <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
